// File: rtl/galois_pkg.sv
// Shared constants and types for the Fermat modular inverter (Q = 3533).
package galois_pkg;

   localparam int unsigned Q   = 3533;
   localparam int unsigned W   = 12;
   localparam int unsigned MU  = 4748;
   localparam int unsigned EXP = 3531;
   localparam int unsigned PW  = 2 * W;
   localparam int unsigned MW  = 13;
   localparam int unsigned IW  = 4;

   localparam logic [W-1:0] EXP_BITS = W'(EXP);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SQR  = 2'd1,
      MUL  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/barrett_reduce_w24.sv
// Combinational Barrett reduction of a 24-bit product into [0, Q).
module barrett_reduce_w24
   import galois_pkg::*;
(
   input  logic [PW-1:0] x,
   output logic [W-1:0]  r
);

   localparam int unsigned XW = PW + 1;
   localparam int unsigned RW = W + 2;

   logic [W-1:0]  qv;
   logic [XW-1:0] qmu;
   logic [MW-1:0] t;
   logic [XW-1:0] tq;
   logic [XW-1:0] diff;
   logic [RW-1:0] r0;
   logic [RW-1:0] r1;
   logic [RW-1:0] r2;

   // Quotient estimate undershoots by at most two, so two corrective subtracts finish the job.
   always_comb begin
      qv   = x[PW-1:W];
      qmu  = XW'(qv) * XW'(MU);
      t    = qmu[W+MW-1:W];
      tq   = XW'(t) * XW'(Q);
      diff = XW'(x) - tq;
      r0   = diff[RW-1:0];
      r1   = (r0 >= RW'(Q)) ? r0 - RW'(Q) : r0;
      r2   = (r1 >= RW'(Q)) ? r1 - RW'(Q) : r1;
      r    = r2[W-1:0];
   end

endmodule

// File: rtl/modinv_fermat_3533.sv
// Sequential modular inverse a^(Q-2) mod Q via left-to-right square-and-multiply.
module modinv_fermat_3533
   import galois_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_r,
   output logic         busy
);

   state_t        state, state_n;
   logic [W-1:0]  acc, acc_n;
   logic [W-1:0]  a_reg, a_n;
   logic [IW-1:0] bit_idx, idx_n;
   logic [W-1:0]  out_r_n;
   logic          out_valid_n;
   logic          in_ready_n;
   logic          busy_n;

   logic [W-1:0]  mul_b;
   logic [PW-1:0] prod;
   logic [W-1:0]  red_r;

   // Shared multiplier: SQR squares acc, MUL multiplies by the operand.
   always_comb begin
      mul_b = (state == MUL) ? a_reg : acc;
      prod  = PW'(acc) * PW'(mul_b);
   end

   barrett_reduce_w24 u_red (
      .x (prod),
      .r (red_r)
   );

   // Next-state, datapath and registered-output updates.
   always_comb begin
      state_n     = state;
      acc_n       = acc;
      a_n         = a_reg;
      idx_n       = bit_idx;
      out_r_n     = out_r;
      out_valid_n = out_valid;
      case (state)
         IDLE: begin
            if (in_valid) begin
               a_n     = (in_a >= W'(Q)) ? in_a - W'(Q) : in_a;
               acc_n   = W'(1);
               idx_n   = IW'(W - 1);
               state_n = SQR;
            end
         end
         SQR: begin
            acc_n = red_r;
            if (EXP_BITS[bit_idx]) begin
               state_n = MUL;
            end else if (bit_idx == '0) begin
               state_n     = DONE;
               out_r_n     = red_r;
               out_valid_n = 1'b1;
            end else begin
               idx_n = bit_idx - IW'(1);
            end
         end
         MUL: begin
            acc_n = red_r;
            if (bit_idx == '0) begin
               state_n     = DONE;
               out_r_n     = red_r;
               out_valid_n = 1'b1;
            end else begin
               idx_n   = bit_idx - IW'(1);
               state_n = SQR;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_n     = IDLE;
               out_valid_n = 1'b0;
            end
         end
         default: state_n = IDLE;
      endcase
      in_ready_n = (state_n == IDLE);
      busy_n     = (state_n != IDLE);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         acc       <= W'(1);
         a_reg     <= '0;
         bit_idx   <= IW'(W - 1);
         out_r     <= '0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
         busy      <= 1'b0;
      end else begin
         state     <= state_n;
         acc       <= acc_n;
         a_reg     <= a_n;
         bit_idx   <= idx_n;
         out_r     <= out_r_n;
         out_valid <= out_valid_n;
         in_ready  <= in_ready_n;
         busy      <= busy_n;
      end
   end

endmodule

// File: tb/tb_modinv_fermat_3533.sv
// Directed and sweep bench for modinv_fermat_3533 and its Barrett reducer.
module tb_modinv_fermat_3533;
   import galois_pkg::*;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_r;
   logic         busy;

   logic [PW-1:0] tx;
   logic [W-1:0]  tr;

   int n_checks;
   int n_errors;

   modinv_fermat_3533 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_r     (out_r),
      .busy      (busy)
   );

   barrett_reduce_w24 u_red_ref (
      .x (tx),
      .r (tr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Runs one operation with nominal latency; returns the result seen in DONE.
   task automatic run_op(input logic [W-1:0] a, input string tag, output logic [W-1:0] r);
      @(negedge clk);
      check({tag, " in_ready"}, in_ready, 1);
      in_valid = 1'b1;
      in_a     = a;
      @(posedge clk);
      #1;
      check({tag, " busy"}, busy, 1);
      @(negedge clk);
      in_valid = 1'b0;
      in_a     = W'($urandom);
      repeat (19) @(posedge clk);
      #1;
      check({tag, " early valid"}, out_valid, 0);
      @(posedge clk);
      #1;
      check({tag, " out_valid"}, out_valid, 1);
      r = out_r;
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check({tag, " valid drop"}, out_valid, 0);
      check({tag, " back idle"}, in_ready, 1);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   logic [W-1:0] res;
   logic [W-1:0] ra;
   longint unsigned xv;

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      out_ready = 1'b0;
      tx        = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Idle after reset, stable for 5 cycles
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("rst in_ready", in_ready, 1);
         check("rst out_valid", out_valid, 0);
         check("rst out_r", out_r, 0);
         check("rst busy", busy, 0);
      end

      // Directed vectors
      run_op(12'd2, "a2", res);    check("inv 2", res, 1767);
      run_op(12'd3, "a3", res);    check("inv 3", res, 1178);
      run_op(12'd1, "a1", res);    check("inv 1", res, 1);
      run_op(12'd3532, "aQm1", res); check("inv Q-1", res, 3532);
      run_op(12'd0, "a0", res);    check("inv 0", res, 0);
      run_op(12'd3533, "aQ", res); check("inv Q", res, 0);
      run_op(12'd3534, "aQp1", res); check("inv Q+1", res, 1);

      // Backpressure: result held, new requests ignored
      @(negedge clk);
      in_valid = 1'b1;
      in_a     = 12'd2;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("bp valid", out_valid, 1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid = i[0];
         in_a     = W'($urandom);
         @(posedge clk);
         #1;
         check("bp out_r", out_r, 1767);
         check("bp out_valid", out_valid, 1);
         check("bp in_ready", in_ready, 0);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp release", out_valid, 0);
      @(negedge clk);
      out_ready = 1'b0;

      // Reset in the middle of a computation
      @(negedge clk);
      in_valid = 1'b1;
      in_a     = 12'd5;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (8) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("mid rst in_ready", in_ready, 1);
      check("mid rst busy", busy, 0);
      check("mid rst out_valid", out_valid, 0);
      check("mid rst out_r", out_r, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (25) @(posedge clk);
      #1;
      check("mid rst no emit", out_valid, 0);
      run_op(12'd3, "post rst", res); check("post rst inv 3", res, 1178);

      // Sweep: a * inverse == 1 mod Q
      for (int i = 0; i < 1000; i++) begin
         ra = W'($urandom_range(3532, 1));
         run_op(ra, "sweep", res);
         check("sweep range", (res < 12'(Q)) ? 1 : 0, 1);
         check("sweep inverse", (longint'(ra) * longint'(res)) % Q, 1);
      end

      // Reducer against plain modulo over [0, Q^2)
      for (int i = 0; i < 20000; i++) begin
         case (i)
            0:       xv = 0;
            1:       xv = Q - 1;
            2:       xv = Q;
            3:       xv = longint'(Q) * Q - 1;
            4:       xv = longint'(Q - 1) * (Q - 1);
            default: xv = longint'($urandom) % (longint'(Q) * Q);
         endcase
         tx = PW'(xv);
         #1;
         check("red golden", tr, xv % Q);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
